// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the ID/EX stage (ALU control, ALU op, forward select).
package riscv_pkg;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // EX/MEM wins over MEM/WB since it holds the younger result; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic                  wr_m,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  wr_w,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic [REG_ADDR_W-1:0] rs
    );
        return (wr_m && rd_m != '0 && rd_m == rs) ? FWD_MEM :
               (wr_w && rd_w != '0 && rd_w == rs) ? FWD_WB  : FWD_REG;
    endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, forward sources and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_d;
    logic [XLEN-1:0] rs1_data_d, rs2_data_d, imm_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic            reg_write_d, mem_read_d, mem_write_d, alu_src_d, r_type_d;
    logic [1:0]      alu_op_d;
    logic [2:0]      funct3_d;
    logic            funct7b5_d;
    logic            flush_e;
    logic [4:0]      rd_m, rd_w;
    logic            reg_write_m, reg_write_w;
    logic [XLEN-1:0] result_m, result_w;
    logic            stall_d;
    logic [XLEN-1:0] A, B;
    logic [2:0]      ALUControl;
    logic            valid_e;
    logic [4:0]      rd_e;
    logic            reg_write_e, mem_read_e, mem_write_e;
    logic [XLEN-1:0] store_data_e;

    modport master (
        output valid_d, rs1_data_d, rs2_data_d, imm_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_read_d, mem_write_d, alu_src_d, r_type_d,
               alu_op_d, funct3_d, funct7b5_d, flush_e,
               rd_m, reg_write_m, result_m, rd_w, reg_write_w, result_w,
        input  stall_d, A, B, ALUControl, valid_e, rd_e,
               reg_write_e, mem_read_e, mem_write_e, store_data_e
    );

    modport slave (
        input  valid_d, rs1_data_d, rs2_data_d, imm_d, rs1_d, rs2_d, rd_d,
               reg_write_d, mem_read_d, mem_write_d, alu_src_d, r_type_d,
               alu_op_d, funct3_d, funct7b5_d, flush_e,
               rd_m, reg_write_m, result_m, rd_w, reg_write_w, result_w,
        output stall_d, A, B, ALUControl, valid_e, rd_e,
               reg_write_e, mem_read_e, mem_write_e, store_data_e
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps alu_op/funct3/funct7b5/r_type to the 3-bit ALU control code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       r_type,
    output logic [2:0] alu_control
);
    logic [2:0] funct_ctrl;

    // funct7b5 only selects SUB for register-register ops; addi with imm[10]=1 stays ADD.
    always_comb begin
        funct_ctrl  = funct3 == 3'b000 ? ((r_type & funct7b5) ? ALU_SUB : ALU_ADD) :
                      funct3 == 3'b010 ? ALU_SLT :
                      funct3 == 3'b110 ? ALU_OR  :
                      funct3 == 3'b111 ? ALU_AND : ALU_ADD;
        alu_control = alu_op == ALUOP_SUB   ? ALU_SUB    :
                      alu_op == ALUOP_FUNCT ? funct_ctrl : ALU_ADD;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection,
// bubble insertion on stall/flush, and EX operand forwarding.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    logic            take;
    logic [2:0]      alu_control_d;
    logic [4:0]      rs1_e, rs2_e;
    logic [XLEN-1:0] rs1_data_e, rs2_data_e, imm_e;
    logic            alu_src_e;
    fwd_sel_e        fwd_a, fwd_b;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    alu_decoder u_alu_decoder (
        .alu_op      (bus.alu_op_d),
        .funct3      (bus.funct3_d),
        .funct7b5    (bus.funct7b5_d),
        .r_type      (bus.r_type_d),
        .alu_control (alu_control_d)
    );

    assign bus.stall_d = bus.valid_e & bus.mem_read_e & (bus.rd_e != 5'd0) &
                         ((bus.rd_e == bus.rs1_d) | (bus.rd_e == bus.rs2_d)) & bus.valid_d;
    assign take = bus.valid_d & ~bus.stall_d & ~bus.flush_e;

    // Datapath fields load unconditionally; only controls are gated to form a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_e     <= 1'b0;
            bus.reg_write_e <= 1'b0;
            bus.mem_read_e  <= 1'b0;
            bus.mem_write_e <= 1'b0;
            bus.rd_e        <= '0;
            bus.ALUControl  <= ALU_ADD;
            rs1_e           <= '0;
            rs2_e           <= '0;
            rs1_data_e      <= '0;
            rs2_data_e      <= '0;
            imm_e           <= '0;
            alu_src_e       <= 1'b0;
        end else begin
            bus.valid_e     <= take;
            bus.reg_write_e <= take & bus.reg_write_d;
            bus.mem_read_e  <= take & bus.mem_read_d;
            bus.mem_write_e <= take & bus.mem_write_d;
            bus.rd_e        <= bus.rd_d;
            bus.ALUControl  <= take ? alu_control_d : ALU_ADD;
            rs1_e           <= bus.rs1_d;
            rs2_e           <= bus.rs2_d;
            rs1_data_e      <= bus.rs1_data_d;
            rs2_data_e      <= bus.rs2_data_d;
            imm_e           <= bus.imm_d;
            alu_src_e       <= bus.alu_src_d;
        end
    end

    assign fwd_a = fwd_select(bus.reg_write_m, bus.rd_m, bus.reg_write_w, bus.rd_w, rs1_e);
    assign fwd_b = fwd_select(bus.reg_write_m, bus.rd_m, bus.reg_write_w, bus.rd_w, rs2_e);

    always_comb begin
        fwd_rs1 = fwd_a == FWD_MEM ? bus.result_m : fwd_a == FWD_WB ? bus.result_w : rs1_data_e;
        fwd_rs2 = fwd_b == FWD_MEM ? bus.result_m : fwd_b == FWD_WB ? bus.result_w : rs2_data_e;
    end

    assign bus.A            = fwd_rs1;
    assign bus.B            = alu_src_e ? imm_e : fwd_rs2;
    assign bus.store_data_e = fwd_rs2;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 valid_d, rs1_data_d, rs2_data_d, imm_d  in  1/XLEN/XLEN/XLEN  decoded instruction from ID.
REQ-005 rs1_d, rs2_d, rd_d  in  5 each  register addresses from ID.
REQ-006 reg_write_d, mem_read_d, mem_write_d, alu_src_d, r_type_d  in  1 each  control from ID.
REQ-007 alu_op_d  in  2  (00 add, 01 sub, 10 funct-decoded); funct3_d in 3; funct7b5_d in 1.
REQ-008 flush_e  in  1  branch-taken kill of the instruction entering EX.
REQ-009 rd_m, reg_write_m, result_m  in  5/1/XLEN  EX/MEM forward source.
REQ-010 rd_w, reg_write_w, result_w  in  5/1/XLEN  MEM/WB forward source.
REQ-011 stall_d  out  1  load-use hazard; ID/IF hold when high.
REQ-012 A, B  out  XLEN  ALU operands; ALUControl  out  3  ALU operation.
REQ-013 valid_e, rd_e, reg_write_e, mem_read_e, mem_write_e  out  1/5/1/1/1  registered EX controls.
REQ-014 store_data_e  out  XLEN  forwarded rs2 for stores.

Function
REQ-015 Stage latency 1 cycle: ID inputs captured on rising clk, visible at EX outputs next cycle.
REQ-016 stall_d = valid_e & mem_read_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d) & valid_d, combinational.
REQ-017 When stall_d=1, next edge loads a bubble: valid_e, reg_write_e, mem_read_e, mem_write_e = 0.
REQ-018 When flush_e=1, next edge loads a bubble; flush_e and stall_d together -> bubble.
REQ-019 Bubble also when valid_d=0; bubble datapath fields hold don't-care but ALUControl=000.
REQ-020 Registered ALUControl: alu_op 00->000, 01->001, 10 by funct3: 000->000 (001 if r_type & funct7b5), 010->101, 110->011, 111->010, other->000.
REQ-021 Forward select per operand, evaluated combinationally on registered rs1_e/rs2_e: EX/MEM if reg_write_m & rd_m!=0 & rd_m==rsX_e; else MEM/WB if reg_write_w & rd_w!=0 & rd_w==rsX_e; else registered reg data.
REQ-022 EX/MEM has priority over MEM/WB when both match.
REQ-023 A = forwarded rs1; B = imm_e if alu_src_e else forwarded rs2; store_data_e = forwarded rs2 always.
REQ-024 Register x0 never forwarded; rs=0 yields registered data (0 from regfile).
REQ-025 No internal back-pressure beyond stall_d; downstream always accepts.

Reset
REQ-026 rst_n low asynchronously clears all pipeline registers: valid_e=0, all controls 0, rd/rs=0, data=0, ALUControl=000.
REQ-027 Reset asserted mid-operation discards the in-flight instruction; stall_d=0 during reset.
REQ-028 First capture occurs on the first rising clk after rst_n deasserts.

Structure
REQ-029 Shared package riscv_pkg holds ALUControl codes (ADD 000, SUB 001, AND 010, OR 011, SLT 101), alu_op codes, forward-select codes (00 reg, 10 EX/MEM, 01 MEM/WB).
REQ-030 One sub-module alu_decoder (alu_op, funct3, funct7b5, r_type -> ALUControl); registers and forwarding muxes stay in id_ex_stage.

Verification
REQ-031 Reset: rst_n=0 mid-stream -> valid_e=0, A=B=0, ALUControl=000 immediately, stall_d=0.
REQ-032 R-type sub: rs1=15, rs2=15, alu_op=10, funct3=000, funct7b5=1, r_type=1 -> next cycle ALUControl=001, A=B=0x0000000F.
REQ-033 Forward priority: rs1_e=5, rd_m=5 result_m=0xAAAA, rd_w=5 result_w=0xBBBB, both reg_write -> A=0x0000AAAA; drop reg_write_m -> A=0x0000BBBB.
REQ-034 x0: rs1_e=0, rd_m=0, reg_write_m=1, result_m=0xDEAD -> A=0.
REQ-035 Load-use: lw x7 in EX, ID reads rs2=7 -> stall_d=1, next cycle valid_e=0 reg_write_e=0; then instruction issues with MEM/WB forward, B=load value.
REQ-036 Flush+stall same cycle, alu_op=10 funct3=010 (SLT) -> bubble, ALUControl=000; next valid SLT -> ALUControl=101.
